serial_adder: RTL
=================

Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes BITS_PER_CYCLE bits per clock using a ripple slice and a registered carry. Operands enter through a valid/ready handshake. The result is held with out_valid until it is consumed. It is the area-lean successor to the single-bit combinational full-adder cell, used wherever a wide add can tolerate multi-cycle latency.

Parameters:
WIDTH, 8, operand and sum width in bits (>=2)
BITS_PER_CYCLE, 1, bits processed per RUN cycle; must divide WIDTH (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/mode valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
C  input  1  carry-in (ignored when Sub=1)
Sub  input  1  0: A+B+C; 1: A+~B+1 (A-B)
out_valid  output  1  S/Co valid, held until out_ready
out_ready  input  1  consumer accepts result
S  output  WIDTH  sum/difference
Co  output  1  final carry-out (Sub=1: 1 = no borrow)

Behaviour:
- Reset (async assert, synchronous-deassert usage): state=IDLE, in_ready=1, out_valid=0, S=0, Co=0, step counter=0, internal operand/carry registers=0. Reset asserted mid-RUN or in DONE aborts the operation. No result is produced.
- N = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, load A, B^{WIDTH{Sub}} and carry=Sub?1:C, clear counter, go to RUN.
  - RUN: in_ready=0. Each edge adds slice [k*BPC +: BPC] with the registered carry, writes the result into S[k*BPC +: BPC], updates carry and increments k. On the edge where k==N-1, Co <= slice carry-out and the state goes to DONE.
  - DONE: out_valid=1. S/Co are stable. On an edge with out_ready=1, go to IDLE and set out_valid=0.
- Latency: accept edge E0. out_valid is visible after edge E_N (N cycles after accept). Throughput is one operation per N+2 cycles minimum (no accept in DONE).
- in_valid is ignored outside IDLE. A/B/C/Sub are sampled only at the accept edge, so later changes have no effect.
- out_ready is ignored outside DONE. If out_ready is high at the entry edge into DONE, the result is still held for at least one cycle.
- S bits not yet computed in RUN hold their previous values. Consumers use S only when out_valid=1.
- Arithmetic is modulo 2^WIDTH. Co is the true carry out of the MSB.
- BITS_PER_CYCLE=WIDTH degenerates to N=1: one RUN cycle.

Optional Feature:
SERIAL_ADDER_OVERFLOW_EN
- Defined: extra output Ovf (1 bit), reset 0. Ovf = carry into MSB XOR carry out of MSB, captured on the last RUN edge. It gives signed two's-complement overflow and is valid with out_valid.
- Undefined: port Ovf absent, no extra logic.

Decomposition:
- Package serial_adder_pkg: state enum {IDLE, RUN, DONE} and the state width constant.
- Sub-module adder_slice (parameter BITS): combinational ripple of BITS full-adder bits. Inputs a, b, cin. Outputs s, cout, and c_msb_in (carry into the top bit, used for Ovf).
- Counter width = $clog2(N) with a minimum of 1.

Test Plan:
1. WIDTH=8, BPC=1: A=8'hFF, B=8'h01, C=0, Sub=0 -> after 8 cycles out_valid=1, S=8'h00, Co=1; with OVERFLOW_EN, Ovf=0.
2. WIDTH=8, BPC=2: A=8'h7F, B=8'h01, C=0, Sub=0 -> after 4 cycles S=8'h80, Co=0, Ovf=1.
3. Subtract, WIDTH=8, BPC=1: A=8'h05, B=8'h07, Sub=1, C=1 (ignored) -> S=8'hFE, Co=0 (borrow).
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> S/Co stable, in_ready=0 throughout, in_valid pulses ignored. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 next cycle.
5. Reset mid-RUN at step 3 of 8 -> immediate in_ready=1, out_valid=0, S=0, Co=0. A new operation (A=8'h10, B=8'h20) then gives S=8'h30, Co=0.
6. Exhaustive WIDTH=4, BPC in {1,2,4}: all A, B, C, Sub combinations -> S/Co match the reference model {Co,S} = A + (Sub?~B:B) + (Sub?1:C).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the multi-cycle serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Step counter must be at least one bit even when a single RUN cycle suffices.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple of BITS full-adder cells; exposes the carry into the top bit.
module adder_slice #(
  parameter int unsigned BITS = 1
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] s,
  output logic            cout,
  output logic            c_msb_in
);

  logic [BITS:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < BITS; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout     = c[BITS];
  assign c_msb_in = c[BITS-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor, BITS_PER_CYCLE bits per clock with a registered carry.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed-overflow output Ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co
`ifdef SERIAL_ADDER_OVERFLOW_EN
  , output logic           Ovf
`endif
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [WIDTH-1:0] SliceMask = WIDTH'({BITS_PER_CYCLE{1'b1}});

  if (WIDTH < 2) begin : gen_width_err
    $error("serial_adder: WIDTH must be at least 2");
  end
  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : gen_bpc_err
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic [CntW-1:0]   k_q, k_d;

  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic                      slice_cout;
  logic                      c_msb;
  logic [WIDTH-1:0]          slice_mask;
  logic                      last_step;

  // Operands shift right each RUN cycle so the active slice always sits in the low bits.
  adder_slice #(
    .BITS(BITS_PER_CYCLE)
  ) u_slice (
    .a       (a_q[BITS_PER_CYCLE-1:0]),
    .b       (b_q[BITS_PER_CYCLE-1:0]),
    .cin     (carry_q),
    .s       (slice_s),
    .cout    (slice_cout),
    .c_msb_in(c_msb)
  );

  assign slice_mask = SliceMask << (k_q * BITS_PER_CYCLE);
  assign last_step  = (k_q == CntW'(N - 1));

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign Ovf = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    k_d     = k_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{Sub}};
          carry_d = Sub | C;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        s_d     = (s_q & ~slice_mask) | ({N{slice_s}} & slice_mask);
        carry_d = slice_cout;
        k_d     = k_q + CntW'(1);
        if (last_step) begin
          co_d    = slice_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = c_msb ^ slice_cout;
`endif
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      k_q     <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      k_q     <= k_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign S         = s_q;
  assign Co        = co_q;

endmodule
